// File: rtl/blinky_pkg.sv
// Shared types for the multi-channel indicator driver: channel modes and the
// configuration record handed from the port decode to each channel.
package blinky_pkg;

    localparam int MODE_W    = 2;
    localparam int CNT_W_MAX = 64;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PWM   = 2'd3
    } mode_t;

    // Sized for the widest supported counter; channels use the low CNT_W bits.
    typedef struct packed {
        mode_t                  mode;
        logic [CNT_W_MAX-1:0]   period;
        logic [CNT_W_MAX-1:0]   duty;
    } chan_cfg_t;

endpackage

// File: rtl/blinky_channel.sv
// One indicator channel: period counter, shadow config for glitch-free
// updates, pending flag and the registered output.
module blinky_channel
    import blinky_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      tick,
    input  logic      restart,
    input  logic      wr,
    input  chan_cfg_t cfg,
    output logic      q,
    output logic      pending
);

    mode_t              mode;
    logic [CNT_W-1:0]   period, duty, sh_period, sh_duty, cnt;
    logic [CNT_W-1:0]   new_period, new_duty, p_last;
    logic               imm, at_end, counting;
    logic [CNT_W_MAX-1:0] unused_cfg_bits;

    assign new_period      = cfg.period[CNT_W-1:0];
    assign new_duty        = cfg.duty[CNT_W-1:0];
    assign unused_cfg_bits = cfg.period ^ cfg.duty;

    // Same-mode BLINK/PWM writes are deferred to the boundary; all else applies now.
    assign imm      = (cfg.mode != mode) || (mode == MODE_OFF) || (mode == MODE_ON);
    assign p_last   = (period == '0) ? '0 : period - CNT_W'(1);
    // >= rather than == so a shrunken period wraps on the next tick.
    assign at_end   = (cnt >= p_last);
    assign counting = (mode == MODE_BLINK) || (mode == MODE_PWM);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode      <= MODE_OFF;
            period    <= '0;
            duty      <= '0;
            sh_period <= '0;
            sh_duty   <= '0;
            cnt       <= '0;
            pending   <= 1'b0;
            q         <= 1'b0;
        end else begin
            case (mode)
                MODE_ON:    q <= 1'b1;
                MODE_PWM:   q <= (cnt < duty);
                MODE_BLINK: begin
                    if (restart)
                        q <= 1'b0;
                    else if (tick && at_end)
                        q <= ~q;
                end
                default:    q <= 1'b0;
            endcase

            if (wr && (imm || restart)) begin
                mode    <= cfg.mode;
                period  <= new_period;
                duty    <= new_duty;
                cnt     <= '0;
                pending <= 1'b0;
                if (cfg.mode == MODE_BLINK)
                    q <= 1'b0;
            end else begin
                if (wr) begin
                    sh_period <= new_period;
                    sh_duty   <= new_duty;
                    pending   <= 1'b1;
                end
                if (restart || (tick && counting && at_end)) begin
                    cnt <= '0;
                    if (pending) begin
                        period  <= sh_period;
                        duty    <= sh_duty;
                        pending <= 1'b0;
                    end
                end else if (tick && counting) begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/blinky_array.sv
// Multi-channel indicator driver: shared prescaler, config port decode and
// an array of independently configured channels.
module blinky_array
    import blinky_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 16,
    parameter int PRESCALE = 1,
    localparam int CHAN_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                restart,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CHAN_W-1:0]   cfg_chan,
    input  logic [MODE_W-1:0]   cfg_mode,
    input  logic [CNT_W-1:0]    cfg_period,
    input  logic [CNT_W-1:0]    cfg_duty,
    output logic [CHANNELS-1:0] q
);

    logic                   tick, rdy, accept;
    logic [CHANNELS-1:0]    pending;
    logic [2**CHAN_W-1:0]   pend_pad;
    chan_cfg_t              wr_cfg;

    generate
        if (PRESCALE <= 1) begin : g_ps1
            assign tick = 1'b1;
        end else begin : g_ps
            localparam int PS_W = $clog2(PRESCALE);
            logic [PS_W-1:0] ps_cnt;

            assign tick = (ps_cnt == PS_W'(PRESCALE - 1));

            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    ps_cnt <= '0;
                else if (restart || tick)
                    ps_cnt <= '0;
                else
                    ps_cnt <= ps_cnt + PS_W'(1);
            end
        end
    endgenerate

    // Holds the port closed until the first edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rdy <= 1'b0;
        else
            rdy <= 1'b1;
    end

    // Out-of-range channel numbers see a clear pending bit, so they are accepted and dropped.
    always_comb begin
        pend_pad                 = '0;
        pend_pad[CHANNELS-1:0]   = pending;
    end

    assign cfg_ready = rdy && !pend_pad[cfg_chan];
    assign accept    = cfg_valid && cfg_ready;

    always_comb begin
        wr_cfg                    = '0;
        wr_cfg.mode               = mode_t'(cfg_mode);
        wr_cfg.period[CNT_W-1:0]  = cfg_period;
        wr_cfg.duty[CNT_W-1:0]    = cfg_duty;
    end

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
            blinky_channel #(.CNT_W(CNT_W)) u_chan (
                .clk     (clk),
                .rst     (rst),
                .tick    (tick),
                .restart (restart),
                .wr      (accept && (cfg_chan == CHAN_W'(i))),
                .cfg     (wr_cfg),
                .q       (q[i]),
                .pending (pending[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_blinky_array.sv
// Directed bench for blinky_array: vector table for OFF/ON/PWM basics plus
// hand-timed sequences for blink, PWM limits, deferred update, restart, reset.
module tb_blinky_array;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        restart = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [1:0]  cfg_chan = '0;
    logic [1:0]  cfg_mode = '0;
    logic [15:0] cfg_period = '0;
    logic [15:0] cfg_duty = '0;
    logic [3:0]  q;

    int n_checks = 0;
    int n_err    = 0;

    blinky_array #(.CHANNELS(4), .CNT_W(16), .PRESCALE(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .restart    (restart),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_chan   (cfg_chan),
        .cfg_mode   (cfg_mode),
        .cfg_period (cfg_period),
        .cfg_duty   (cfg_duty),
        .q          (q)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         v;
        int         ch;
        int         md;
        int         per;
        int         dty;
        bit         rdy;
        logic [3:0] q;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input int ch, input int md, input int per,
                         input int dty, input bit rs);
        cfg_valid  = v;
        cfg_chan   = 2'(ch);
        cfg_mode   = 2'(md);
        cfg_period = 16'(per);
        cfg_duty   = 16'(dty);
        restart    = rs;
    endtask

    task automatic write(input int ch, input int md, input int per, input int dty, input bit rs);
        drive(1'b1, ch, md, per, dty, rs);
        cyc();
        drive(1'b0, ch, 0, 0, 0, 1'b0);
    endtask

    initial begin
        // modes: 0 OFF, 1 ON, 2 BLINK, 3 PWM; q sampled after each edge
        tbl[0]  = '{1'b1, 0, 1, 0, 0, 1'b1, 4'b0000};
        tbl[1]  = '{1'b0, 0, 0, 0, 0, 1'b1, 4'b0001};
        tbl[2]  = '{1'b0, 0, 0, 0, 0, 1'b1, 4'b0001};
        tbl[3]  = '{1'b1, 0, 0, 0, 0, 1'b1, 4'b0001};
        tbl[4]  = '{1'b0, 0, 0, 0, 0, 1'b1, 4'b0000};
        tbl[5]  = '{1'b1, 3, 1, 0, 0, 1'b1, 4'b0000};
        tbl[6]  = '{1'b1, 0, 1, 0, 0, 1'b1, 4'b1000};
        tbl[7]  = '{1'b0, 0, 0, 0, 0, 1'b1, 4'b1001};
        tbl[8]  = '{1'b1, 3, 0, 0, 0, 1'b1, 4'b1001};
        tbl[9]  = '{1'b1, 2, 3, 0, 1, 1'b1, 4'b0001};
        tbl[10] = '{1'b0, 0, 0, 0, 0, 1'b1, 4'b0101};
        tbl[11] = '{1'b0, 0, 0, 0, 0, 1'b1, 4'b0101};
        tbl[12] = '{1'b1, 0, 0, 0, 0, 1'b1, 4'b0101};
        tbl[13] = '{1'b1, 2, 0, 0, 0, 1'b1, 4'b0100};
        tbl[14] = '{1'b0, 0, 0, 0, 0, 1'b1, 4'b0000};

        // reset state
        #2;
        chk("reset_q", q, 0);
        chk("reset_rdy", cfg_ready, 0);
        cyc();
        cyc();
        chk("reset_q_held", q, 0);
        chk("reset_rdy_held", cfg_ready, 0);
        #2 rst = 1'b1;
        cyc();
        chk("rdy_after_release", cfg_ready, 1);
        chk("q_after_release", q, 0);

        // OFF/ON and trivial PWM vectors
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].v, tbl[i].ch, tbl[i].md, tbl[i].per, tbl[i].dty, 1'b0);
            #1;
            chk($sformatf("vec%0d_rdy", i), cfg_ready, tbl[i].rdy);
            cyc();
            chk($sformatf("vec%0d_q", i), q, tbl[i].q);
        end
        drive(1'b0, 0, 0, 0, 0, 1'b0);

        // BLINK period 4 at prescale 3: toggle every 12 clocks
        write(1, 2, 4, 0, 1'b0);
        restart = 1'b1;
        cyc();
        restart = 1'b0;
        chk("blink4_k0", q[1], 0);
        for (int k = 1; k <= 26; k++) begin
            cyc();
            chk($sformatf("blink4_k%0d", k), q[1], (k / 12) % 2);
        end

        // period 0 acts as 1; write with restart applies at once
        write(1, 2, 0, 0, 1'b1);
        chk("blink0_k0", q[1], 0);
        for (int k = 1; k <= 12; k++) begin
            cyc();
            chk($sformatf("blink0_k%0d", k), q[1], (k / 3) % 2);
        end

        // PWM period 10 duty 3, then duty 0 and duty 15
        write(2, 3, 10, 3, 1'b1);
        for (int k = 1; k <= 32; k++) begin
            cyc();
            chk($sformatf("pwm3_k%0d", k), q[2], ((((k - 1) / 3) % 10) < 3) ? 1 : 0);
        end
        write(2, 3, 10, 0, 1'b1);
        for (int k = 1; k <= 20; k++) begin
            cyc();
            chk($sformatf("pwm0_k%0d", k), q[2], 0);
        end
        write(2, 3, 10, 15, 1'b1);
        for (int k = 1; k <= 20; k++) begin
            cyc();
            chk($sformatf("pwm15_k%0d", k), q[2], 1);
        end
        write(2, 0, 0, 0, 1'b0);
        write(1, 0, 0, 0, 1'b0);

        // deferred update: period 8 -> 2 written mid-period, second write stalled
        write(1, 2, 8, 0, 1'b1);
        chk("defer_k0", q[1], 0);
        for (int k = 1; k <= 45; k++) begin
            if (k == 9)
                drive(1'b1, 1, 2, 2, 0, 1'b0);
            else if (k >= 10 && k <= 14)
                drive(1'b1, 1, 2, 6, 0, 1'b0);
            else if (k == 15)
                drive(1'b0, 0, 0, 0, 0, 1'b0);
            else
                drive(1'b0, 1, 0, 0, 0, 1'b0);
            #1;
            if (k >= 9 && k <= 16 || k == 20 || k == 24 || k == 25)
                chk($sformatf("defer_rdy_k%0d", k), cfg_ready,
                    (k == 9 || k == 15 || k == 25) ? 1 : 0);
            cyc();
            chk($sformatf("defer_q_k%0d", k), q[1],
                (k < 24) ? 0 : ((((k - 24) / 6) % 2 == 0) ? 1 : 0));
        end
        drive(1'b0, 0, 0, 0, 0, 1'b0);
        write(1, 0, 0, 0, 1'b0);

        // restart aligns two BLINK channels running at different phases
        write(0, 2, 5, 0, 1'b1);
        for (int k = 1; k <= 17; k++) begin
            if (k == 6)
                drive(1'b1, 1, 2, 5, 0, 1'b0);
            else
                drive(1'b0, 0, 0, 0, 0, 1'b0);
            cyc();
        end
        drive(1'b0, 0, 0, 0, 0, 1'b0);
        chk("align_pre", q[1:0], 2'b01);
        restart = 1'b1;
        cyc();
        restart = 1'b0;
        chk("align_k0", q[1:0], 2'b00);
        for (int k = 1; k <= 16; k++) begin
            cyc();
            chk($sformatf("align_k%0d", k), q[1:0], (k >= 15) ? 3 : 0);
        end

        // async reset while PWM/BLINK run and a write is pending
        write(2, 3, 10, 15, 1'b0);
        write(1, 2, 2, 0, 1'b0);
        cyc();
        cyc();
        drive(1'b0, 1, 0, 0, 0, 1'b0);
        #1;
        chk("pend_before_rst", cfg_ready, 0);
        chk("pwm_before_rst", q[2], 1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_q", q, 0);
        chk("async_rst_rdy", cfg_ready, 0);
        cyc();
        chk("async_rst_q_edge", q, 0);
        #3 rst = 1'b1;
        cyc();
        chk("post_rst_rdy", cfg_ready, 1);
        chk("post_rst_q", q, 0);
        for (int k = 1; k <= 30; k++) begin
            cyc();
            chk($sformatf("post_rst_off_k%0d", k), q, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/blinky_array.md
# blinky_array

Multi-channel, run-time-configurable successor to the single-output blinker. It drives `CHANNELS` independent indicator outputs from one shared prescaler, and each output runs in one of four modes: OFF, ON, BLINK or PWM. Each channel's period and duty are written at run time through a valid/ready configuration port. Updates to a running channel take effect glitch-free at that channel's next period boundary. The block sits at the framework level, between control/status logic and board LEDs or debug pins.

## Interface
- `CHANNELS`, 4: number of output channels, 1..64.
- `CNT_W`, 16: width of the period, duty and per-channel counters.
- `PRESCALE`, 1: clk cycles per tick. A value of 1 means one tick every cycle.

- `clk` input, 1: the single clock; all logic is on its rising edge.
- `rst` input, 1: asynchronous, active-low reset.
- `restart` input, 1: single-cycle strobe that phase-aligns all channels.
- `cfg_valid` input, 1: configuration write request.
- `cfg_ready` output, 1: configuration port can accept a write.
- `cfg_chan` input, max(1,$clog2(CHANNELS)): target channel.
- `cfg_mode` input, 2: 0=OFF, 1=ON, 2=BLINK, 3=PWM.
- `cfg_period` input, CNT_W: period in ticks.
- `cfg_duty` input, CNT_W: PWM high time in ticks.
- `q` output, CHANNELS: registered channel outputs.

## Operation
- **Reset.**
  - Reset is asynchronous and active-low; `rst`=0 forces all state immediately.
  - On reset: `q`=0, every channel mode=OFF, period=0, duty=0, counters=0, pending=0, prescaler=0.
  - `cfg_ready` is 0 while in reset and 1 from the first edge after release.
- **Prescaler.**
  - Counts 0..PRESCALE-1 and asserts `tick` when it reaches PRESCALE-1, then wraps to 0.
  - When PRESCALE=1, `tick` is held at 1.
- **Effective period.** A period of 0 is treated as 1.
- **Per-channel counter.**
  - Advances only on `tick`.
  - At 0..P-1 it wraps to 0; the wrap is the *period boundary*.
  - In OFF and ON the counter is held at 0.
- **Modes.**
  - OFF: `q`=0.
  - ON: `q`=1.
  - BLINK: `q` toggles at every period boundary, giving a full cycle of 2·P ticks.
  - PWM: `q` = (count < duty). duty=0 gives a constant 0; duty ≥ P gives a constant 1.
- **Handshake.**
  - A write is accepted when `cfg_valid`=1 and `cfg_ready`=1 on the same edge.
  - `cfg_ready` = !pending[cfg_chan], combinational from the registered pending flags and `cfg_chan`.
  - A `cfg_chan` value ≥ CHANNELS is accepted and discarded.
- **Immediate apply** happens when the new mode differs from the current mode, or the current mode is OFF or ON:
  - mode, period and duty load at the accept edge;
  - the counter is cleared;
  - a BLINK channel restarts with `q`=0.
- **Deferred apply** happens when the mode is unchanged and is BLINK or PWM:
  - period and duty go into the channel's shadow registers and pending is set;
  - on the next period-boundary tick the shadow values load and pending clears.
- **Restart.**
  - `restart` clears the prescaler and all counters.
  - Every BLINK `q` is forced to 0.
  - Any pending shadow values load immediately.
- **Simultaneous events.**
  - An accept coinciding with `restart` is applied immediately.
  - Restart has priority over tick.
- **Width rules.**
  - All counter comparisons are unsigned CNT_W.
  - The counter never exceeds P-1, even after a period shrinks: a loaded period smaller than count+1 forces a wrap on the next tick.

## Timing
- Every `q` bit is registered.
- OFF/ON immediate writes change `q` on the edge after the accept edge, i.e. 1 cycle of latency.
- PWM `q` reflects the counter value with 1 cycle of latency.
- A BLINK toggle occurs on the edge after the boundary tick.
- Deferred apply takes effect within P_old ticks of the accept.
- `cfg_ready` for the affected channel falls on the edge after the accept and rises on the edge after the boundary.

## Structure
- `blinky_pkg`:
  - `mode_t` enum (OFF, ON, BLINK, PWM);
  - the `MODE_W`=2 constant;
  - a `chan_cfg_t` struct holding mode, period and duty.
- `blinky_channel`, one per channel: counter, shadow registers, pending flag and `q`. Inputs are `tick`, `restart`, the write strobe and the config.
- The top level holds the prescaler, channel decode and `cfg_ready` mux, and a generate loop of `blinky_channel`.

## Test plan
- **Reset and OFF/ON:** reset, then write ch0 ON → `q[0]`=1 two edges after accept; write ch0 OFF → `q[0]`=0; check `cfg_ready` stays 1 throughout.
- **BLINK with prescale:** PRESCALE=3, ch1 BLINK period=4 → `q[1]` toggles every 12 clk cycles; period=0 → toggles every 3 cycles.
- **PWM duty limits:** ch2 PWM period=10 with duty=3 → high 3 of every 10 ticks; duty=0 → constant 0; duty=15 → constant 1.
- **Deferred update:** ch1 BLINK period=8, then period=2 written mid-period → no change until the boundary, then 2-tick toggles; `cfg_ready` is low for ch1 and high for ch0 while pending; a second write to ch1 is stalled.
- **Restart alignment:** ch0 and ch1 in BLINK period=5 at different phases, pulse `restart` → both counters are 0 and both `q` are 0, then they toggle on the same edge.
- **Async reset mid-operation:** assert `rst` low between clock edges while PWM/BLINK are active and a write is pending → `q`=0 immediately, pending cleared, all channels OFF after release.
